// File: rtl/puf_pkg.sv
// Shared widths and FSM encoding for the PUF key reader and its per-bit voters.
`timescale 1ns/1ps
package puf_pkg;

    localparam int PUF_WIDTH  = 256;
    localparam int PUF_CTRL_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_REARM   = 3'd3,
        ST_VOTE    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/puf_bit_voter.sv
// Counts how many captured samples of one synchronised PUF bit were 1 and
// derives the majority value and a not-unanimous flag from that count.
`timescale 1ns/1ps
module puf_bit_voter #(
    parameter int NUM_SAMPLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic bit_in,
    output logic majority,
    output logic unstable
);

    localparam int CW = $clog2(NUM_SAMPLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(bit_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign majority = (cnt_q > CW'(NUM_SAMPLES / 2));
    assign unstable = (cnt_q != '0) && (cnt_q != CW'(NUM_SAMPLES));

endmodule

// File: rtl/puf_key_reader.sv
// Drives a PUF generator through NUM_SAMPLES settle/capture rounds, majority-votes
// every response bit into a device key and reports how many bits were not unanimous.
`timescale 1ns/1ps
module puf_key_reader
    import puf_pkg::*;
#(
    parameter int WIDTH         = PUF_WIDTH,
    parameter int NUM_SAMPLES   = 5,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PUF_CTRL_W-1:0]      challenge,
    output logic                       busy,
    output logic                       puf_enable,
    output logic [PUF_CTRL_W-1:0]      puf_control,
    input  logic [WIDTH-1:0]           puf_response,
    output logic [WIDTH-1:0]           key,
    output logic                       key_valid,
    input  logic                       key_ack,
    output logic [$clog2(WIDTH+1)-1:0] unstable_count
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int IW = $clog2(NUM_SAMPLES + 1);
    localparam int UW = $clog2(WIDTH + 1);

    state_e                state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  puf_enable_q, puf_enable_d;
    logic [PUF_CTRL_W-1:0] puf_control_q, puf_control_d;
    logic [WIDTH-1:0]      key_q, key_d;
    logic                  key_valid_q, key_valid_d;
    logic [UW-1:0]         unst_q, unst_d;
    logic [WIDTH-1:0]      sync1_q, sync2_q;

    logic                  voter_clr;
    logic                  voter_inc;
    logic [WIDTH-1:0]      maj_vec;
    logic [WIDTH-1:0]      unst_vec;
    logic [UW-1:0]         unst_pop;

    for (genvar i = 0; i < WIDTH; i++) begin : g_voter
        puf_bit_voter #(
            .NUM_SAMPLES(NUM_SAMPLES)
        ) u_voter (
            .clk     (clk),
            .rst     (rst),
            .clr     (voter_clr),
            .inc     (voter_inc),
            .bit_in  (sync2_q[i]),
            .majority(maj_vec[i]),
            .unstable(unst_vec[i])
        );
    end

    always_comb begin
        unst_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unst_pop = unst_pop + UW'(unst_vec[i]);
        end
    end

    // Key handshake: key is offered while key_valid is high and stays frozen until
    // the consumer raises key_ack; the cycle after that the key is zeroised.
    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        idx_d         = idx_q;
        puf_enable_d  = puf_enable_q;
        puf_control_d = puf_control_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        unst_d        = unst_q;
        voter_clr     = 1'b0;
        voter_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                puf_enable_d  = 1'b0;
                puf_control_d = '0;
                if (start) begin
                    puf_control_d = challenge;
                    voter_clr     = 1'b1;
                    idx_d         = '0;
                    settle_d      = '0;
                    unst_d        = '0;
                    puf_enable_d  = 1'b1;
                    state_d       = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = ST_CAPTURE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                voter_inc    = 1'b1;
                idx_d        = idx_q + 1'b1;
                puf_enable_d = 1'b0;
                if (idx_q == IW'(NUM_SAMPLES - 1)) begin
                    state_d = ST_VOTE;
                end else begin
                    state_d = ST_REARM;
                end
            end
            ST_REARM: begin
                puf_enable_d = 1'b1;
                settle_d     = '0;
                state_d      = ST_SETTLE;
            end
            ST_VOTE: begin
                key_d       = maj_vec;
                unst_d      = unst_pop;
                key_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (key_ack) begin
                    key_d         = '0;
                    key_valid_d   = 1'b0;
                    puf_control_d = '0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            idx_q         <= '0;
            puf_enable_q  <= 1'b0;
            puf_control_q <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            unst_q        <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            idx_q         <= idx_d;
            puf_enable_q  <= puf_enable_d;
            puf_control_q <= puf_control_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            unst_q        <= unst_d;
            sync1_q       <= puf_response;
            sync2_q       <= sync1_q;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign puf_enable     = puf_enable_q;
    assign puf_control    = puf_control_q;
    assign key            = key_q;
    assign key_valid      = key_valid_q;
    assign unstable_count = unst_q;

endmodule
